layer_sequencer: RTL and testbench

Layer-level control initiator that drives the start/mode/w8/finish handshake of the convolution accelerator. Walks a descriptor list held in a single-port descriptor RAM, programs one layer at a time (3x3 conv, 1x1 conv, max-pool) and waits for each layer's `finish`. Reports completion or error to the EPU host logic. Sits between the EPU register file and the accelerator.

---
 rtl/layer_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_layer_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Layer sequencer: walks a two-word-per-layer descriptor list and drives the
// convolution accelerator's start/mode/w8/finish handshake one layer at a time.
module layer_sequencer #(
  parameter int unsigned DESC_AW = 8,
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               go,
  input  logic [DESC_AW-1:0] base_addr,
  input  logic [7:0]         num_layers,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [7:0]         layer_idx,
  output logic               desc_cs,
  output logic [DESC_AW-1:0] desc_addr,
  input  logic [31:0]        desc_rdata,
  output logic [3:0]         acc_mode,
  output logic               acc_start,
  output logic [31:0]        acc_w8,
  input  logic               acc_finish
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch0 = 3'd1;
  localparam logic [2:0] StFetch1 = 3'd2;
  localparam logic [2:0] StLatch  = 3'd3;
  localparam logic [2:0] StStart  = 3'd4;
  localparam logic [2:0] StRun    = 3'd5;
  localparam logic [2:0] StNext   = 3'd6;
  localparam logic [2:0] StDone   = 3'd7;

  // Accelerator mode bit indices
  localparam logic [1:0] IdleMode    = 2'd0;
  localparam logic [1:0] Conv3x3Mode = 2'd1;
  localparam logic [1:0] Conv1x1Mode = 2'd2;
  localparam logic [1:0] MaxPoolMode = 2'd3;

  localparam int unsigned WdW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  logic [2:0]         state_q, state_d;
  logic [DESC_AW-1:0] ptr_q, ptr_d;
  logic [7:0]         nl_q, nl_d;
  logic [1:0]         op_q, op_d;
  logic [WdW-1:0]     wd_q, wd_d;
  logic [7:0]         idx_q, idx_d;
  logic               err_q, err_d;
  logic [31:0]        w8_q, w8_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cs_q, cs_d;
  logic [DESC_AW-1:0] addr_q, addr_d;
  logic [3:0]         mode_q, mode_d;
  logic               start_q, start_d;
  logic [3:0]         layer_mode;

  always_comb begin
    layer_mode = '0;
    unique case (op_q)
      2'd0:    layer_mode[Conv3x3Mode] = 1'b1;
      2'd1:    layer_mode[Conv1x1Mode] = 1'b1;
      2'd2:    layer_mode[MaxPoolMode] = 1'b1;
      default: layer_mode[IdleMode]    = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    nl_d    = nl_q;
    op_d    = op_q;
    wd_d    = wd_q;
    idx_d   = idx_q;
    err_d   = err_q;
    w8_d    = w8_q;
    case (state_q)
      StIdle: begin
        if (go) begin
          err_d   = 1'b0;
          idx_d   = 8'd0;
          ptr_d   = base_addr;
          nl_d    = num_layers;
          state_d = (num_layers == 8'd0) ? StDone : StFetch0;
        end
      end
      StFetch0: state_d = StFetch1;
      StFetch1: begin
        op_d    = desc_rdata[1:0];
        state_d = StLatch;
      end
      StLatch: begin
        w8_d = desc_rdata;
        if (op_q == 2'd3) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StStart;
        end
      end
      StStart: begin
        wd_d    = '0;
        state_d = StRun;
      end
      StRun: begin
        // Finish wins over a watchdog expiring in the same cycle
        if (acc_finish) begin
          state_d = StNext;
        end else if (wd_q == WdLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StNext: begin
        if (idx_q == nl_q - 8'd1) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 8'd1;
          ptr_d   = ptr_q + DESC_AW'(2);
          state_d = StFetch0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    busy_d  = (state_d != StIdle) && (state_d != StDone);
    done_d  = (state_d == StDone);
    start_d = (state_d == StStart);
    cs_d    = (state_d == StFetch0) || (state_d == StFetch1);
    addr_d  = addr_q;
    if (state_d == StFetch0) begin
      addr_d = ptr_d;
    end else if (state_d == StFetch1) begin
      addr_d = ptr_q + DESC_AW'(1);
    end
    mode_d = 4'b0001;
    if ((state_d == StStart) || (state_d == StRun) || (state_d == StNext)) begin
      mode_d = layer_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      nl_q    <= '0;
      op_q    <= '0;
      wd_q    <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      w8_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      addr_q  <= '0;
      mode_q  <= 4'b0001;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      nl_q    <= nl_d;
      op_q    <= op_d;
      wd_q    <= wd_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      w8_q    <= w8_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      start_q <= start_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign layer_idx = idx_q;
  assign desc_cs   = cs_q;
  assign desc_addr = addr_q;
  assign acc_mode  = mode_q;
  assign acc_start = start_q;
  assign acc_w8    = w8_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: descriptor RAM and accelerator responder models, a
// directed vector table, hand-written reset/disturbance sequences and random runs.
module tb_layer_sequencer;

  localparam int Tmo = 16;

  logic        clk;
  logic        rstn;
  logic        go;
  logic [7:0]  base_addr;
  logic [7:0]  num_layers;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  layer_idx;
  logic        desc_cs;
  logic [7:0]  desc_addr;
  logic [31:0] desc_rdata;
  logic [3:0]  acc_mode;
  logic        acc_start;
  logic [31:0] acc_w8;
  logic        acc_finish;

  logic        resp_fin;
  logic        glitch;

  assign acc_finish = resp_fin | glitch;

  layer_sequencer #(
    .DESC_AW(8),
    .TIMEOUT(Tmo)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .go        (go),
    .base_addr (base_addr),
    .num_layers(num_layers),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .layer_idx (layer_idx),
    .desc_cs   (desc_cs),
    .desc_addr (desc_addr),
    .desc_rdata(desc_rdata),
    .acc_mode  (acc_mode),
    .acc_start (acc_start),
    .acc_w8    (acc_w8),
    .acc_finish(acc_finish)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] mem [256];
  int          dly_tab [4];
  bit          never_fin = 1'b0;
  int          lay_cnt   = 0;
  int          lay_base  = 0;

  logic [7:0]  addr_log [$];
  logic [3:0]  mode_log [$];
  logic [31:0] w8_log [$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  bit          done_err = 1'b0;

  bit run_active = 1'b0;
  int go_ref     = 0;
  int exp_done   = 0;

  typedef struct {
    logic [7:0]        base;
    logic [7:0]        n;
    logic [3:0][1:0]   ops;
    logic [3:0][31:0]  w8s;
    logic [3:0][4:0]   dlys;
    bit                nofin;
    bit                disturb;
    int                x_starts;
    bit                x_err;
    int                x_done;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] mode_of(input logic [1:0] op);
    case (op)
      2'd0:    return 4'b0010;
      2'd1:    return 4'b0100;
      2'd2:    return 4'b1000;
      default: return 4'b0001;
    endcase
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port descriptor RAM, one-cycle read latency
  initial desc_rdata = '0;
  always @(posedge clk) begin
    if (desc_cs) desc_rdata <= mem[desc_addr];
  end

  // Accelerator: raises finish for one cycle, dly_tab[layer] RUN cycles after start
  initial begin
    int cnt;
    logic [3:0] cur_mode;
    int li;
    cnt = 0;
    cur_mode = 4'b0001;
    resp_fin = 1'b0;
    forever begin
      @(negedge clk);
      resp_fin = 1'b0;
      if (!rstn) begin
        cnt = 0;
      end else if (acc_start) begin
        cur_mode = acc_mode;
        li = lay_cnt - lay_base;
        cnt = (never_fin || li < 0 || li > 3) ? 0 : dly_tab[li];
        lay_cnt++;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          resp_fin = 1'b1;
          check("mode_held_at_finish", acc_mode, cur_mode);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (desc_cs) addr_log.push_back(desc_addr);
    if (acc_start) begin
      mode_log.push_back(acc_mode);
      w8_log.push_back(acc_w8);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err;
      check("busy_at_done", busy, 1'b0);
      check("mode_idle_at_done", acc_mode, 4'b0001);
    end
    if (run_active && cyc > go_ref) begin
      check("busy_window", busy, (cyc < go_ref + exp_done) ? 1'b1 : 1'b0);
    end
  end

  task automatic check_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_layer_idx", layer_idx, 8'd0);
    check("rst_desc_cs", desc_cs, 1'b0);
    check("rst_desc_addr", desc_addr, 8'd0);
    check("rst_acc_mode", acc_mode, 4'b0001);
    check("rst_acc_start", acc_start, 1'b0);
    check("rst_acc_w8", acc_w8, 32'd0);
  endtask

  task automatic run_case(input logic [7:0] base, input logic [7:0] n,
                          input logic [3:0][1:0] ops, input logic [3:0][31:0] w8s,
                          input logic [3:0][4:0] dlys, input bit nofin, input bit disturb,
                          output int got_starts, output bit got_err, output int got_off);
    logic [31:0] r;
    logic [7:0]  a0;
    logic [1:0]  op;
    int          f, s, x_off, x_idx, ab, sb, db;
    bit          x_err;
    logic [7:0]  xa [$];
    logic [3:0]  xm [$];
    logic [31:0] xw [$];
    for (int i = 0; i < int'(n); i++) begin
      r = $urandom();
      mem[base + 8'(2 * i)]     = {r[31:2], ops[i]};
      mem[base + 8'(2 * i + 1)] = w8s[i];
      dly_tab[i] = int'(dlys[i]);
    end
    // Reference: event times in cycles after go is sampled
    x_err = 1'b0;
    x_idx = 0;
    x_off = 1;
    f = 1;
    for (int i = 0; i < int'(n); i++) begin
      a0 = base + 8'(2 * i);
      op = mem[a0][1:0];
      xa.push_back(a0);
      xa.push_back(a0 + 8'd1);
      x_idx = i;
      if (op == 2'd3) begin
        x_err = 1'b1;
        x_off = f + 3;
        break;
      end
      s = f + 3;
      xm.push_back(mode_of(op));
      xw.push_back(mem[a0 + 8'd1]);
      if (nofin) begin
        x_err = 1'b1;
        x_off = s + 1 + Tmo;
        break;
      end
      if (i == int'(n) - 1) x_off = s + int'(dlys[i]) + 2;
      else f = s + int'(dlys[i]) + 2;
    end

    never_fin = nofin;
    lay_base  = lay_cnt;
    ab = addr_log.size();
    sb = mode_log.size();
    db = done_cnt;
    @(negedge clk);
    exp_done   = x_off;
    go_ref     = cyc;
    base_addr  = base;
    num_layers = n;
    go         = 1'b1;
    run_active = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("err_cleared_on_go", err, 1'b0);
    if (disturb) glitch = 1'b1;
    for (int t = 0; t < 300 && done_cnt == db; t++) begin
      @(negedge clk);
      glitch = 1'b0;
      if (disturb && cyc == go_ref + 8) begin
        go         = 1'b1;
        base_addr  = 8'h77;
        num_layers = 8'd0;
      end else begin
        go = 1'b0;
      end
    end
    go = 1'b0;
    glitch = 1'b0;
    repeat (3) @(negedge clk);
    run_active = 1'b0;

    got_off    = done_cyc - go_ref;
    got_err    = done_err;
    got_starts = mode_log.size() - sb;
    check("done_count", done_cnt - db, 1);
    check("done_time", got_off, x_off);
    check("err_at_done", done_err, x_err);
    check("err_sticky", err, x_err);
    check("final_layer_idx", layer_idx, x_idx);
    check("start_count", got_starts, xm.size());
    check("addr_count", addr_log.size() - ab, xa.size());
    for (int i = 0; i < xa.size(); i++) begin
      if (ab + i < addr_log.size()) check("desc_addr", addr_log[ab + i], xa[i]);
    end
    for (int i = 0; i < xm.size(); i++) begin
      if (sb + i < mode_log.size()) begin
        check("acc_mode", mode_log[sb + i], xm[i]);
        check("acc_w8", w8_log[sb + i], xw[i]);
      end
    end
  endtask

  initial begin
    int gs, goff, db;
    bit ge;
    logic [3:0][1:0]  rops;
    logic [3:0][31:0] rw8;
    logic [3:0][4:0]  rdly;
    logic [31:0]      r;

    // base, n, ops{l3..l0}, w8{l3..l0}, dly{l3..l0}, nofin, disturb, starts, err, done
    vecs[0] = '{8'h10, 8'd2, {2'd0, 2'd0, 2'd2, 2'd0},
                {32'h0, 32'h0, 32'h5A, 32'hA5}, {5'd0, 5'd0, 5'd10, 5'd10},
                1'b0, 1'b1, 2, 1'b0, 31};
    // num_layers=0 goes straight to DONE
    vecs[1] = '{8'h30, 8'd0, {2'd0, 2'd0, 2'd0, 2'd0},
                {32'h0, 32'h0, 32'h0, 32'h0}, {5'd0, 5'd0, 5'd0, 5'd0},
                1'b0, 1'b0, 0, 1'b0, 1};
    vecs[2] = '{8'h20, 8'd3, {2'd0, 2'd0, 2'd3, 2'd1},
                {32'h0, 32'h3333, 32'h2222, 32'h1111}, {5'd0, 5'd4, 5'd4, 5'd5},
                1'b0, 1'b0, 1, 1'b1, 14};
    vecs[3] = '{8'hFF, 8'd1, {2'd0, 2'd0, 2'd0, 2'd1},
                {32'h0, 32'h0, 32'h0, 32'hCAFEF00D}, {5'd0, 5'd0, 5'd0, 5'd3},
                1'b0, 1'b0, 1, 1'b0, 9};
    vecs[4] = '{8'h40, 8'd1, {2'd0, 2'd0, 2'd0, 2'd0},
                {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, {5'd0, 5'd0, 5'd0, 5'd0},
                1'b1, 1'b0, 1, 1'b1, 21};
    vecs[5] = '{8'h80, 8'd3, {2'd0, 2'd0, 2'd1, 2'd2},
                {32'h0, 32'h3, 32'h2, 32'h1}, {5'd0, 5'd7, 5'd16, 5'd1},
                1'b0, 1'b0, 3, 1'b0, 40};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) dly_tab[i] = 1;
    rstn       = 1'b0;
    go         = 1'b0;
    base_addr  = 8'h0;
    num_layers = 8'h0;
    glitch     = 1'b0;
    repeat (2) @(negedge clk);
    check_reset();
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check_reset();

    for (int v = 0; v < 6; v++) begin
      run_case(vecs[v].base, vecs[v].n, vecs[v].ops, vecs[v].w8s, vecs[v].dlys,
               vecs[v].nofin, vecs[v].disturb, gs, ge, goff);
      check("tbl_starts", gs, vecs[v].x_starts);
      check("tbl_err", ge, vecs[v].x_err);
      check("tbl_done_time", goff, vecs[v].x_done);
    end

    // Reset asserted while a layer is running
    mem[8'h50] = 32'h0;
    mem[8'h51] = 32'h1234;
    dly_tab[0] = 10;
    never_fin  = 1'b0;
    lay_base   = lay_cnt;
    db = done_cnt;
    @(negedge clk);
    base_addr  = 8'h50;
    num_layers = 8'd1;
    go         = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_before_reset", busy, 1'b1);
    check("mode_before_reset", acc_mode, 4'b0010);
    rstn = 1'b0;
    @(negedge clk);
    check_reset();
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_reset", done_cnt - db, 0);
    check("idle_after_reset", busy, 1'b0);

    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 7);
        rops[i] = (r == 7) ? 2'd3 : 2'(r % 3);
        rw8[i]  = $urandom();
        rdly[i] = 5'($urandom_range(1, 16));
      end
      run_case(8'($urandom_range(0, 255)), 8'($urandom_range(0, 4)), rops, rw8, rdly,
               ($urandom_range(0, 9) == 0), 1'b0, gs, ge, goff);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
